// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch unit with a single-outstanding memory port and a DEPTH-entry {pc,ins} queue
module fetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        ins_valid,
  output logic [31:0] ins,
  output logic [31:0] ins_pc,
  input  logic        ins_ready
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   drain_addr_q, drain_addr_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0]   pc_mem  [DEPTH];
  logic [31:0]   ins_mem [DEPTH];

  logic          push;
  logic          pop;
  logic [CW-1:0] count_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while count_q covers them.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= fetch_pc_q;
      ins_mem[wr_ptr_q] <= mem_rdata;
    end
  end

  always_comb begin
    push         = (state_q == ST_WAIT) && mem_ack && !redirect;
    pop          = (count_q != '0) && ins_ready && !redirect;
    count_nx     = count_q + CW'(push) - CW'(pop);

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    count_d      = count_nx;
    wr_ptr_d     = wr_ptr_q + PW'(push);
    rd_ptr_d     = rd_ptr_q + PW'(pop);

    if (redirect) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    case (state_q)
      ST_IDLE: begin
        if (!redirect && (count_nx < DEPTH_C)) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (redirect) begin
          // An unanswered request must still be retired before refetching.
          if (mem_ack) begin
            state_d = ST_IDLE;
          end else begin
            state_d      = ST_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end else if (mem_ack) begin
          state_d = (count_nx < DEPTH_C) ? ST_WAIT : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (mem_ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_req   = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign mem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign ins_valid = (count_q != '0);
  assign ins       = ins_valid ? ins_mem[rd_ptr_q] : NOP;
  assign ins_pc    = ins_valid ? pc_mem[rd_ptr_q] : 32'h0000_0000;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        ins_valid;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        ins_ready;

  int passed = 0;
  int total  = 0;

  fetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ins_valid   (ins_valid),
    .ins         (ins),
    .ins_pc      (ins_pc),
    .ins_ready   (ins_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ack, input logic [31:0] data, input logic rdy,
                       input logic rdr, input logic [31:0] rpc);
    mem_ack     = ack;
    mem_rdata   = data;
    ins_ready   = rdy;
    redirect    = rdr;
    redirect_pc = rpc;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
    chk("rst_ins_valid", {31'b0, ins_valid}, 32'd0);
    chk("rst_ins", ins, 32'h0000_0013);
    chk("rst_ins_pc", ins_pc, 32'h0);

    rst_n = 1'b1;
    tick();
    chk("first_req", {31'b0, mem_req}, 32'd1);
    chk("first_addr", mem_addr, 32'h0);

    // back-to-back acks with decode always ready
    drive(1'b1, 32'h0000_1000, 1'b1, 1'b0, 32'h0);
    tick();
    chk("b2b_pc0", ins_pc, 32'h0);
    chk("b2b_ins0", ins, 32'h0000_1000);
    chk("b2b_addr4", mem_addr, 32'h4);
    drive(1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'h0);
    tick();
    chk("b2b_pc4", ins_pc, 32'h4);
    chk("b2b_ins4", ins, 32'h0000_1004);
    chk("b2b_addr8", mem_addr, 32'h8);
    drive(1'b1, 32'h0000_1008, 1'b1, 1'b0, 32'h0);
    tick();
    chk("b2b_pc8", ins_pc, 32'h8);
    chk("b2b_addr12", mem_addr, 32'hC);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("b2b_empty_valid", {31'b0, ins_valid}, 32'd0);
    chk("b2b_empty_ins", ins, 32'h0000_0013);
    chk("b2b_still_wait", {31'b0, mem_req}, 32'd1);

    // asynchronous reset mid-request, then a stray ack after release
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_req", {31'b0, mem_req}, 32'd0);
    chk("async_rst_valid", {31'b0, ins_valid}, 32'd0);
    chk("async_rst_ins", ins, 32'h0000_0013);
    rst_n = 1'b1;
    drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0);
    tick();
    chk("stray_no_push", {31'b0, ins_valid}, 32'd0);
    chk("stray_req", {31'b0, mem_req}, 32'd1);
    chk("stray_addr", mem_addr, 32'h0);

    // fill the queue with decode stalled
    drive(1'b1, 32'h0000_2000, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_2004, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b1, 32'h0000_2008, 1'b0, 1'b0, 32'h0);
    tick();
    chk("fill_addr12", mem_addr, 32'hC);
    drive(1'b1, 32'h0000_200C, 1'b0, 1'b0, 32'h0);
    tick();
    chk("full_req", {31'b0, mem_req}, 32'd0);
    chk("full_valid", {31'b0, ins_valid}, 32'd1);
    chk("full_pc", ins_pc, 32'h0);
    chk("full_ins", ins, 32'h0000_2000);
    drive(1'b1, 32'h0000_5A5A, 1'b0, 1'b0, 32'h0);
    tick();
    chk("full_hold_req", {31'b0, mem_req}, 32'd0);
    chk("full_hold_pc", ins_pc, 32'h0);
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    chk("resume_req", {31'b0, mem_req}, 32'd1);
    chk("resume_addr", mem_addr, 32'h10);
    chk("resume_pc", ins_pc, 32'h4);
    chk("resume_ins", ins, 32'h0000_2004);
    tick();
    chk("pop_to_two_pc", ins_pc, 32'h8);

    // redirect coinciding with ack and pop at count 2
    drive(1'b1, 32'h0000_0BAD, 1'b1, 1'b1, 32'h0000_0040);
    tick();
    chk("rdr_ack_valid", {31'b0, ins_valid}, 32'd0);
    chk("rdr_ack_req", {31'b0, mem_req}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rdr_ack_addr", mem_addr, 32'h40);
    drive(1'b1, 32'h0000_3040, 1'b0, 1'b0, 32'h0);
    tick();
    chk("rdr_ack_pc", ins_pc, 32'h40);
    chk("rdr_ack_ins", ins, 32'h0000_3040);
    chk("rdr_ack_next", mem_addr, 32'h44);

    // redirect while waiting: drain the stale response first
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0103);
    tick();
    chk("drain_req", {31'b0, mem_req}, 32'd1);
    chk("drain_addr", mem_addr, 32'h44);
    chk("drain_flush", {31'b0, ins_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    chk("drain_hold_addr", mem_addr, 32'h44);
    drive(1'b1, 32'h0000_7777, 1'b0, 1'b0, 32'h0);
    tick();
    chk("drain_done_req", {31'b0, mem_req}, 32'd0);
    chk("drain_discard", {31'b0, ins_valid}, 32'd0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("refetch_addr", mem_addr, 32'h100);
    chk("refetch_empty", {31'b0, ins_valid}, 32'd0);
    drive(1'b1, 32'h0000_3100, 1'b0, 1'b0, 32'h0);
    tick();
    chk("refetch_pc", ins_pc, 32'h100);
    chk("refetch_ins", ins, 32'h0000_3100);

    // redirect during DRAIN only reloads fetch_pc; then wrap at top of address space
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0200);
    tick();
    chk("drain2_addr", mem_addr, 32'h104);
    drive(1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFD);
    tick();
    chk("drain_rdr_req", {31'b0, mem_req}, 32'd1);
    chk("drain_rdr_addr", mem_addr, 32'h104);
    drive(1'b1, 32'h0000_9999, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
    drive(1'b1, 32'h0000_5555, 1'b0, 1'b0, 32'h0);
    tick();
    chk("wrap_next", mem_addr, 32'h0);
    chk("wrap_pc", ins_pc, 32'hFFFF_FFFC);
    chk("wrap_ins", ins, 32'h0000_5555);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, instruction queue entries (power of two, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port redirect  input  1  branch/jump taken; flush and refetch.
REQ-006 SHALL have port redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0).
REQ-007 SHALL have port mem_req  output  1  instruction memory request.
REQ-008 SHALL have port mem_addr  output  32  word-aligned request address.
REQ-009 SHALL have port mem_ack  input  1  response valid this cycle for the outstanding request.
REQ-010 SHALL have port mem_rdata  input  32  instruction word, sampled only when mem_ack=1.
REQ-011 SHALL have port ins_valid  output  1  queue head holds a valid instruction.
REQ-012 SHALL have port ins  output  32  head instruction; 32'h00000013 (NOP) when ins_valid=0.
REQ-013 SHALL have port ins_pc  output  32  address of head instruction; 0 when ins_valid=0.
REQ-014 SHALL have port ins_ready  input  1  decode consumes head when ins_valid=1.

Function
REQ-015 SHALL hold fetch_pc register, state machine {IDLE, WAIT, DRAIN}, and FIFO of DEPTH {pc,ins} entries with count 0..DEPTH.
REQ-016 SHALL drive mem_req=1 exactly in WAIT and DRAIN; mem_addr SHALL equal fetch_pc in WAIT and the stale address in DRAIN, stable until mem_ack.
REQ-017 SHALL allow at most one outstanding memory request; mem_ack outside WAIT/DRAIN SHALL be ignored.
REQ-018 IDLE -> WAIT when count_next < DEPTH and redirect=0; otherwise stay IDLE.
REQ-019 WAIT with mem_ack=1, redirect=0: push {fetch_pc, mem_rdata}, fetch_pc += 4 (32-bit wrap), next state WAIT if count_next < DEPTH else IDLE.
REQ-020 WAIT with mem_ack=0: stay WAIT.
REQ-021 Pop SHALL occur when ins_valid=1 and ins_ready=1; count_next = count + push - pop; simultaneous push and pop SHALL leave count unchanged.
REQ-022 Push into a full queue SHALL never occur (guaranteed by REQ-018/019); queue pointers SHALL wrap modulo DEPTH.
REQ-023 redirect=1 SHALL, at that edge: clear FIFO (count=0), discard any same-cycle mem_ack data and pop, load fetch_pc = {redirect_pc[31:2],2'b00}.
REQ-024 redirect in WAIT with mem_ack=0 SHALL go to DRAIN; redirect in WAIT with mem_ack=1, or in IDLE, SHALL go to IDLE.
REQ-025 DRAIN: on mem_ack discard response, go to IDLE; redirect in DRAIN SHALL only reload fetch_pc.
REQ-026 ins_valid SHALL be 1 iff count != 0; ins/ins_pc SHALL be driven from the FIFO head combinationally.
REQ-027 Latency: first mem_req cycle after reset release is one cycle; acked word SHALL appear on ins the cycle after mem_ack.

Reset
REQ-028 rst_n=0 SHALL asynchronously force state=IDLE, fetch_pc=RESET_PC, count=0, FIFO pointers=0, hence mem_req=0, ins_valid=0, ins=32'h00000013, ins_pc=0.
REQ-029 Reset asserted mid-request SHALL abandon the outstanding request; a late mem_ack after release SHALL be ignored (state IDLE).
REQ-030 Reset deassertion SHALL take effect at the next rising clk edge only.

Verification
REQ-031 Reset release, memory acks every cycle, ins_ready=1 -> mem_addr 0,4,8,... back-to-back; ins_pc sequence 0,4,8 one cycle after each ack.
REQ-032 ins_ready=0, continuous acks -> exactly DEPTH(4) pushes, mem_req drops, ins_valid=1, ins_pc=0 held; ins_ready=1 -> fetch resumes at 16.
REQ-033 redirect with redirect_pc=32'h103 while WAIT, ack 3 cycles later -> DRAIN, that response discarded, next mem_addr=32'h100, ins_valid=0 until its ack.
REQ-034 redirect same cycle as mem_ack and pop with count=2 -> count=0, ack data not enqueued, fetch_pc=redirect_pc.
REQ-035 rst_n pulsed low mid-WAIT, then stray mem_ack after release -> outputs per REQ-028, no push, first mem_addr=RESET_PC.
REQ-036 fetch_pc=32'hFFFFFFFC acked -> next mem_addr=32'h00000000.
